// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller.
// Holds opcode and funct codes, ALUOp and ALUControl encodings, and the
// FSM state encoding. The top level and the ALU decoder both import it.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_MUL = 6'b011100;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b100;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALU_MUL = 3'b101;
  localparam logic [ALUCTL_W-1:0] ALU_NOP = 3'b000;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_RSVD  = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field to ALUControl.
// Ports: i_alu_op (ALUOp), i_funct (IR[5:0]), o_alu_control (ALU operation).
// Purely combinational.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [ALUOP_W-1:0]  i_alu_op,
  input  logic [FUNCT_W-1:0]  i_funct,
  output logic [ALUCTL_W-1:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_SLT:  o_alu_control = ALU_SLT;
          FN_MUL:  o_alu_control = ALU_MUL;
          default: o_alu_control = ALU_NOP;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS controller: Moore FSM sequencing each instruction over
// 3-5 cycles plus memory waits, driving the shared-ALU/unified-memory datapath.
// Inputs : clk, rst (sync, active-high), Opcode, Funct, Zero, mem_ready.
// Outputs: mux selects (IorD, ALUSrcA, ALUSrcB, RegDest, memtoReg, PCSrc),
//          enables (IRWrite, memWrite, RegWrite, PCEn), ALUControl,
//          illegal_op pulse and state_o for debug. All outputs combinational.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH      = OPCODE_W,
  parameter int unsigned FUNCT_WIDTH       = FUNCT_W,
  parameter int unsigned ALUOP_WIDTH       = ALUOP_W,
  parameter int unsigned ALU_CONTROL_WIDTH = ALUCTL_W,
  parameter int unsigned STATE_WIDTH       = STATE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OPCODE_WIDTH-1:0]      Opcode,
  input  logic [FUNCT_WIDTH-1:0]       Funct,
  input  logic                         Zero,
  input  logic                         mem_ready,
  output logic                         IorD,
  output logic                         ALUSrcA,
  output logic                         RegDest,
  output logic                         memtoReg,
  output logic [1:0]                   ALUSrcB,
  output logic [1:0]                   PCSrc,
  output logic                         IRWrite,
  output logic                         memWrite,
  output logic                         RegWrite,
  output logic                         PCEn,
  output logic [ALU_CONTROL_WIDTH-1:0] ALUControl,
  output logic                         illegal_op,
  output logic [STATE_WIDTH-1:0]       state_o
);

  state_e                 r_state;
  state_e                 w_next;
  logic [ALUOP_WIDTH-1:0] w_alu_op;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state and Moore output decode; reset overrides with FETCH selects.
  always_comb begin
    w_next     = S_FETCH;
    w_alu_op   = ALUOP_ADD;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    RegDest    = 1'b0;
    memtoReg   = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IRWrite    = 1'b0;
    memWrite   = 1'b0;
    RegWrite   = 1'b0;
    PCEn       = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = S_EXECUTE;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDIEX;
          OP_J:           w_next = S_JUMP;
          default: begin
            w_next     = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        memWrite = 1'b1;
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA  = 1'b1;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        RegDest  = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_alu_op = ALUOP_SUB;
        PCSrc    = 2'b01;
        // bne shares the state; its taken sense is the inverse of beq.
        PCEn     = Zero ^ (Opcode == OP_BNE);
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    if (rst) begin
      w_alu_op   = ALUOP_ADD;
      IorD       = 1'b0;
      ALUSrcA    = 1'b0;
      RegDest    = 1'b0;
      memtoReg   = 1'b0;
      ALUSrcB    = 2'b01;
      PCSrc      = 2'b00;
      IRWrite    = 1'b0;
      memWrite   = 1'b0;
      RegWrite   = 1'b0;
      PCEn       = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state_o = rst ? STATE_WIDTH'(S_FETCH) : STATE_WIDTH'(r_state);

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct       (Funct),
    .o_alu_control (ALUControl)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: the driver expands each instruction into its cycle steps,
// pushes the expected output word per cycle, and a negedge monitor compares.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode, Funct;
  logic       Zero, mem_ready;
  logic       IorD, ALUSrcA, RegDest, memtoReg;
  logic [1:0] ALUSrcB, PCSrc;
  logic       IRWrite, memWrite, RegWrite, PCEn;
  logic [2:0] ALUControl;
  logic       illegal_op;
  logic [3:0] state_o;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDest(RegDest),
    .memtoReg(memtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .memWrite(memWrite), .RegWrite(RegWrite), .PCEn(PCEn),
    .ALUControl(ALUControl), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef enum int {K_F, K_D, K_MA, K_MR, K_MB, K_MW, K_EX, K_AW, K_BR, K_AE, K_AB, K_J} kind_e;
  typedef struct { kind_e k; logic mr; } step_t;

  logic [19:0] exp_q[$];
  step_t       steps[$];
  int          checks = 0;
  int          errors = 0;

  // Output word: {state, IorD, ALUSrcA, RegDest, memtoReg, ALUSrcB, PCSrc,
  //               IRWrite, memWrite, RegWrite, PCEn, ALUControl, illegal_op}
  function automatic logic [19:0] expect_cycle(kind_e k, logic mr, logic z,
                                               logic [5:0] op, logic [5:0] fn, logic r);
    logic [3:0] st; logic [1:0] srcb, pcsrc; logic [2:0] aluc;
    logic iord, srca, rdst, m2r, irw, mw, rw, pcen, ill;
    st = 4'd0; srcb = 2'b00; pcsrc = 2'b00; aluc = 3'b010;
    iord = 0; srca = 0; rdst = 0; m2r = 0; irw = 0; mw = 0; rw = 0; pcen = 0; ill = 0;
    if (r) begin
      srcb = 2'b01;
    end else begin
      case (k)
        K_F:  begin st = 4'd0; srcb = 2'b01; irw = mr; pcen = mr; end
        K_D:  begin
          st = 4'd1; srcb = 2'b11;
          ill = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J});
        end
        K_MA: begin st = 4'd2; srca = 1; srcb = 2'b10; end
        K_MR: begin st = 4'd3; iord = 1; end
        K_MB: begin st = 4'd4; m2r = 1; rw = 1; end
        K_MW: begin st = 4'd5; iord = 1; mw = 1; end
        K_EX: begin
          st = 4'd6; srca = 1;
          case (fn)
            6'b100000: aluc = 3'b010;
            6'b100010: aluc = 3'b100;
            6'b101010: aluc = 3'b110;
            6'b011100: aluc = 3'b101;
            default:   aluc = 3'b000;
          endcase
        end
        K_AW: begin st = 4'd7; rdst = 1; rw = 1; end
        K_BR: begin st = 4'd8; srca = 1; aluc = 3'b100; pcsrc = 2'b01; pcen = z ^ (op == 6'b000101); end
        K_AE: begin st = 4'd9; srca = 1; srcb = 2'b10; end
        K_AB: begin st = 4'd10; rw = 1; end
        default: begin st = 4'd11; pcsrc = 2'b10; pcen = 1; end
      endcase
    end
    return {st, iord, srca, rdst, m2r, srcb, pcsrc, irw, mw, rw, pcen, aluc, ill};
  endfunction

  task automatic cyc(input kind_e k, input logic mr, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic r);
    Opcode = op; Funct = fn; Zero = z; mem_ready = mr; rst = r;
    exp_q.push_back(expect_cycle(k, mr, z, op, fn, r));
    @(posedge clk); #1;
  endtask

  function automatic int pick_w(int wf);
    return (wf >= 0) ? wf : int'($urandom_range(0, 3));
  endfunction

  task automatic add_mem(input kind_e k, input int w);
    repeat (w) steps.push_back('{k, 1'b0});
    steps.push_back('{k, 1'b1});
  endtask

  task automatic add_plain(input kind_e k);
    steps.push_back('{k, 1'($urandom_range(0, 1))});
  endtask

  // cls: 0 lw, 1 sw, 2 R-type, 3 beq, 4 bne, 5 addi, 6 j, 7 illegal (op = ill_op)
  task automatic issue(input int cls, input logic [5:0] fn, input logic z,
                       input int wf, input int rst_idx, input logic [5:0] ill_op);
    logic [5:0] op;
    case (cls)
      0: op = OP_LW;   1: op = OP_SW;   2: op = OP_RTYPE; 3: op = OP_BEQ;
      4: op = OP_BNE;  5: op = OP_ADDI; 6: op = OP_J;     default: op = ill_op;
    endcase
    steps.delete();
    add_mem(K_F, pick_w(wf));
    add_plain(K_D);
    case (cls)
      0: begin add_plain(K_MA); add_mem(K_MR, pick_w(wf)); add_plain(K_MB); end
      1: begin add_plain(K_MA); add_mem(K_MW, pick_w(wf)); end
      2: begin add_plain(K_EX); add_plain(K_AW); end
      3, 4: add_plain(K_BR);
      5: begin add_plain(K_AE); add_plain(K_AB); end
      6: add_plain(K_J);
      default: ;
    endcase
    for (int i = 0; i < steps.size(); i++) begin
      if (i == rst_idx) begin
        cyc(K_F, 1'($urandom_range(0, 1)), op, fn, z, 1'b1);
        break;
      end
      cyc(steps[i].k, steps[i].mr, op, fn, z, 1'b0);
    end
  endtask

  // Monitor: every cycle the DUT presents an output word; compare with the queue head.
  always @(negedge clk) begin
    logic [19:0] got, exp_w;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      got = {state_o, IorD, ALUSrcA, RegDest, memtoReg, ALUSrcB, PCSrc,
             IRWrite, memWrite, RegWrite, PCEn, ALUControl, illegal_op};
      checks++;
      if (got !== exp_w) begin
        errors++;
        $display("FAIL ctrl_word t=%0t state got %0d exp %0d word got %05h exp %05h",
                 $time, got[19:16], exp_w[19:16], got, exp_w);
      end
    end
  end

  initial begin
    logic [5:0] fns[4];
    logic [5:0] fn, ill;
    int cls, ridx;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b101010; fns[3] = 6'b011100;
    rst = 1'b1; Opcode = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc(K_F, 1'b0, 6'b0, 6'b0, 1'b0, 1'b1);
    cyc(K_F, 1'b1, 6'b0, 6'b0, 1'b1, 1'b1);

    issue(0, 6'b100000, 1'b0, 0, -1, 6'b0);   // lw zero wait
    issue(1, 6'b100000, 1'b0, 3, -1, 6'b0);   // sw, 3 waits
    issue(2, 6'b100010, 1'b0, 0, -1, 6'b0);   // R-type sub
    issue(2, 6'b111111, 1'b1, 0, -1, 6'b0);   // unknown funct
    issue(3, 6'b0, 1'b1, 0, -1, 6'b0);
    issue(3, 6'b0, 1'b0, 0, -1, 6'b0);
    issue(4, 6'b0, 1'b1, 0, -1, 6'b0);
    issue(4, 6'b0, 1'b0, 0, -1, 6'b0);
    issue(7, 6'b0, 1'b0, 0, -1, 6'b111111);  // illegal opcode
    issue(0, 6'b0, 1'b0, 0, 3, 6'b0);         // reset in MEMRD
    issue(5, 6'b0, 1'b0, 0, -1, 6'b0);
    issue(6, 6'b0, 1'b0, 0, -1, 6'b0);

    for (int n = 0; n < 400; n++) begin
      cls = int'($urandom_range(0, 7));
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 3)];
      ill = 6'($urandom);
      while (ill inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J})
        ill = 6'($urandom);
      ridx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
      issue(cls, fn, 1'($urandom_range(0, 1)), -1, ridx, ill);
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle controller for the MIPS datapath: a Moore-style FSM that sequences each instruction over 3–5 cycles and shares one ALU and one unified memory port. It keeps the single-cycle unit's opcode/funct decode and ALUControl encoding. It adds a memory wait handshake, `bne` support and illegal-opcode flagging. It sits between the instruction register and the multicycle datapath muxes and enables.

## Interface
- `OPCODE_WIDTH`, 6: opcode field width.
- `FUNCT_WIDTH`, 6: funct field width.
- `ALUOP_WIDTH`, 2: internal ALUOp width.
- `ALU_CONTROL_WIDTH`, 3: ALUControl width.
- `STATE_WIDTH`, 4: state register width, also the width of `state_o`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `Opcode` in OPCODE_WIDTH: IR[31:26]; sampled only in DECODE.
- `Funct` in FUNCT_WIDTH: IR[5:0].
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `IorD`, `ALUSrcA`, `RegDest`, `memtoReg` out 1 each: datapath mux selects.
- `ALUSrcB` out 2: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- `PCSrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `IRWrite`, `memWrite`, `RegWrite`, `PCEn` out 1 each: datapath enables.
- `ALUControl` out ALU_CONTROL_WIDTH: ALU operation.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state_o` out STATE_WIDTH: current state, for debug.

## Operation
- **States and encodings:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unused; if reached, go to FETCH next cycle with all enables 0.
- **FETCH:** IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCEn=`mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) or 000101 (bne) → BRANCH.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JUMP.
  - Any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD for lw, MEMWR for sw.
- **MEMRD:** IorD=1. Stay while `mem_ready`=0, then MEMWB.
- **MEMWB:** RegDest=0, memtoReg=1, RegWrite=1. Next: FETCH.
- **MEMWR:** IorD=1, memWrite=1 for every cycle in the state. Stay while `mem_ready`=0, then FETCH.
- **EXECUTE:** ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- **ALUWB:** RegDest=1, memtoReg=0, RegWrite=1. Next: FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01.
  - PCEn = Zero XOR (Opcode==000101).
  - Next: FETCH.
- **ADDIEX:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
- **ADDIWB:** RegDest=0, memtoReg=0, RegWrite=1. Next: FETCH.
- **JUMP:** PCSrc=10, PCEn=1. Next: FETCH.
- **ALU decode (combinational from ALUOp and Funct):**
  - ALUOp 00 → 010; ALUOp 01 → 100.
  - ALUOp 10 by Funct: 100000 → 010, 100010 → 100, 101010 → 110, 011100 → 101, other → 000.
  - ALUOp 11 → 010.
- **Output defaults:** every output not listed for a state is 0.

## Timing
- **Outputs:** combinational from the state register, plus `mem_ready`, `Zero` and `Opcode` where listed above. No output registers.
- **Reset:**
  - While `rst`=1, every enable (IRWrite, memWrite, RegWrite, PCEn) is forced to 0, and `illegal_op`=0.
  - The mux selects and `state_o` show the FETCH values while `rst`=1.
  - On the first edge with `rst`=1, the state becomes FETCH.
  - Reset asserted mid-instruction abandons that instruction; no further write occurs.
- **Cycle counts with `mem_ready` tied to 1:** lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3. Each extra wait cycle adds one cycle in FETCH, MEMRD or MEMWR.
- **Mid-wait behaviour:** `mem_ready` dropping mid-wait simply extends the wait. memWrite stays high across the whole MEMWR wait; the memory is required to tolerate that.
- **Illegal opcode:** `illegal_op` is a single-cycle pulse in DECODE. The instruction retires in 2 cycles with no architectural write except PC+4 (already done in FETCH).

## Structure
- **Package `mips_ctrl_pkg`:**
  - Opcode constants (LW, SW, RTYPE, BEQ, BNE, ADDI, J).
  - Funct constants (ADD, SUB, SLT, MUL).
  - ALUControl codes.
  - ALUOp codes.
  - State encodings.
- **Sub-module:** one combinational sub-module, `alu_decoder` (ALUOp, Funct → ALUControl), instantiated once.
- **Top level:** the state register, next-state logic and output decode.

## Test plan
- **lw, zero wait:** reset, then Opcode=100011, `mem_ready`=1.
  - Required: `state_o` sequence 0,1,2,3,4,0.
  - RegWrite=1 with memtoReg=1 only in state 4.
  - PCEn=1 only in the FETCH cycle.
- **sw with 3 wait cycles:** `mem_ready` low for 3 cycles in MEMWR.
  - Required: memWrite=1 for 4 consecutive cycles, then FETCH.
  - RegWrite stays 0 throughout.
- **R-type sub and unknown funct:**
  - Funct=100010 → ALUControl=100 in EXECUTE, RegDest=1 in ALUWB.
  - Funct=111111 → ALUControl=000.
- **beq/bne:** all four combinations.
  - beq with Zero=1 → PCEn=1 in BRANCH; beq with Zero=0 → PCEn=0.
  - bne inverts both results.
  - PCSrc=01 in BRANCH in every case.
- **Illegal opcode and reset:**
  - Opcode=111111 → `illegal_op` pulses for exactly 1 cycle in DECODE, next state FETCH, no writes.
  - Assert `rst` in MEMRD → all enables 0 immediately; `state_o`=0 after the edge.
